e_mdu: RTL and testbench

E_MDU -- requirements
Module: e_mdu

---
 rtl/e_mdu_pkg.sv | 39 +++
 rtl/mdu_arith.sv | 54 +++++
 rtl/e_mdu.sv | 115 +++++++++++
 tb/tb_e_mdu.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/e_mdu_pkg.sv
// E-stage multiply/divide unit: shared op encodings, state type and default latencies.
// Divide-by-zero guard is selected with DIV_ZERO_GUARD_EN.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_e;

  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;

  function automatic logic is_start(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit HI/LO result for the latched MDU op and operands.
// Signed divide works on magnitudes so INT_MIN / -1 wraps to INT_MIN.
module mdu_arith
  import e_mdu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] quo_m;
  logic [31:0] rem_m;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic        b_zero;

  always_comb begin
    prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
    prod_u = {32'd0, a_i} * {32'd0, b_i};
    mag_a  = a_i[31] ? -a_i : a_i;
    mag_b  = b_i[31] ? -b_i : b_i;
    b_zero = (b_i == 32'd0);
    quo_m  = b_zero ? 32'd0 : mag_a / mag_b;
    rem_m  = b_zero ? 32'd0 : mag_a % mag_b;
    quo_u  = b_zero ? 32'd0 : a_i / b_i;
    rem_u  = b_zero ? 32'd0 : a_i % b_i;
    quo_s  = (a_i[31] ^ b_i[31]) ? -quo_m : quo_m;
    rem_s  = a_i[31] ? -rem_m : rem_m;
    hi_o   = 32'd0;
    lo_o   = 32'd0;
    case (op_i)
      MD_MULT:  {hi_o, lo_o} = prod_s;
      MD_MULTU: {hi_o, lo_o} = prod_u;
      MD_DIV: begin
        hi_o = b_zero ? a_i : rem_s;
        lo_o = b_zero ? 32'hFFFF_FFFF : quo_s;
      end
      MD_DIVU: begin
        hi_o = b_zero ? a_i : rem_u;
        lo_o = b_zero ? 32'hFFFF_FFFF : quo_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage MDU: multi-cycle MULT/DIV sequencer owning HI/LO and the busy flag.
// Define DIV_ZERO_GUARD_EN to keep HI/LO untouched on divide by zero.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] V1,
  input  logic [31:0] V2,
  input  logic        cancel,
  output logic        start,
  output logic        busy,
  output logic [31:0] rdata
);

  localparam logic [3:0] MUL_N = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        wr_hl;

  mdu_arith u_arith (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .hi_o (res_hi),
    .lo_o (res_lo)
  );

`ifdef DIV_ZERO_GUARD_EN
  assign wr_hl = !(is_div(op_q) && (b_q == 32'd0));
`else
  assign wr_hl = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= MD_NONE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    start   = is_start(md_op) && !cancel;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d = md_op;
          a_d  = V1;
          b_d  = V2;
          if (is_mul(md_op)) begin
            cnt_d   = MUL_N;
            state_d = S_MUL;
          end else begin
            cnt_d   = DIV_N;
            state_d = S_DIV;
          end
        end else if (!cancel && md_op == MD_MTHI) begin
          hi_d = V1;
        end else if (!cancel && md_op == MD_MTLO) begin
          lo_d = V1;
        end
      end
      S_MUL, S_DIV: begin
        cnt_d = cnt_q - 4'd1;
        // Commit only on the last busy edge; HI/LO never see partials.
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          if (wr_hl) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy  = (state_q != S_IDLE);
  assign rdata = (md_op == MD_MFHI) ? hi_q :
                 (md_op == MD_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: scoreboarded HI/LO results, busy timing,
// cancel, MTHI/MTLO, divide-by-zero and reset behaviour.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  md_op = MD_NONE;
  logic [31:0] V1 = 32'd0;
  logic [31:0] V2 = 32'd0;
  logic        cancel = 1'b0;
  logic        start;
  logic        busy;
  logic [31:0] rdata;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;

  logic [63:0] sb_q[$];

  e_mdu dut (
    .clk    (clk),
    .reset  (reset),
    .md_op  (md_op),
    .V1     (V1),
    .V2     (V2),
    .cancel (cancel),
    .start  (start),
    .busy   (busy),
    .rdata  (rdata)
  );

  always #5 clk = ~clk;

  // Hazard unit must stall start/MTHI/MTLO while busy.
  always @(negedge clk) begin
    if (reset === 1'b0 && busy === 1'b1) begin
      total_cnt++;
      assert (!(start === 1'b1 || md_op == MD_MTHI || md_op == MD_MTLO))
        pass_cnt++;
      else begin
        fail_cnt++;
        $error("FAIL hazard: op %0d issued while busy", md_op);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_hl(input string tag);
    logic [63:0] e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      md_op = MD_MFHI;
      #1;
      chk({tag, "_hi"}, rdata, e[63:32]);
      md_op = MD_MFLO;
      #1;
      chk({tag, "_lo"}, rdata, e[31:0]);
      md_op = MD_NONE;
      #1;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int cyc, input int cancel_at);
    int n;
    md_op  = op;
    V1     = a;
    V2     = b;
    cancel = 1'b0;
    #1;
    chk({tag, "_start"}, {31'd0, start}, 32'd1);
    tick();
    md_op = MD_NONE;
    V1    = 32'hA5A5_A5A5;
    V2    = 32'h5A5A_5A5A;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      cancel = (n == cancel_at);
      n++;
      tick();
    end
    cancel = 1'b0;
    chk({tag, "_busy_cycles"}, n, cyc);
  endtask

  initial begin
    // Reset with a pending MULT: reset wins.
    md_op = MD_MULT;
    V1 = 32'd2;
    V2 = 32'd3;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    md_op = MD_NONE;
    reset = 1'b0;
    #1;
    chk("rst_busy_after", {31'd0, busy}, 32'd0);
    sb_q.push_back({32'd0, 32'd0});
    read_hl("rst");

    sb_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFA});
    run_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5, -1);
    read_hl("mult");

    sb_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, -1);
    read_hl("multu");

    sb_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div_cancel", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 2);
    read_hl("div");

    sb_q.push_back({32'd1, 32'd3});
    run_op("divu", MD_DIVU, 32'd7, 32'd2, 10, -1);
    read_hl("divu");

    sb_q.push_back({32'd0, 32'h8000_0000});
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, -1);
    read_hl("div_ovf");

    md_op = MD_MTHI;
    V1 = 32'h1234_5678;
    tick();
    md_op = MD_MFHI;
    #1;
    chk("mthi_mfhi", rdata, 32'h1234_5678);

    md_op = MD_MTLO;
    V1 = 32'hDEAD_BEEF;
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    sb_q.push_back({32'h1234_5678, 32'h8000_0000});
    read_hl("mtlo_cancel");

    md_op = MD_MTLO;
    V1 = 32'hCAFE_F00D;
    tick();
    sb_q.push_back({32'h1234_5678, 32'hCAFE_F00D});
    read_hl("mtlo");

    md_op = MD_MULT;
    V1 = 32'd2;
    V2 = 32'd3;
    cancel = 1'b1;
    #1;
    chk("cancel_start", {31'd0, start}, 32'd0);
    tick();
    tick();
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    md_op = MD_NONE;
    cancel = 1'b0;
    sb_q.push_back({32'h1234_5678, 32'hCAFE_F00D});
    read_hl("cancel_hl");

`ifdef DIV_ZERO_GUARD_EN
    sb_q.push_back({32'h1234_5678, 32'hCAFE_F00D});
`else
    sb_q.push_back({32'd5, 32'hFFFF_FFFF});
`endif
    run_op("divz", MD_DIVU, 32'd5, 32'd0, 10, -1);
    read_hl("divz");

    // Reset in the fourth busy cycle of a MULT.
    md_op = MD_MULT;
    V1 = 32'd7;
    V2 = 32'd9;
    tick();
    md_op = MD_NONE;
    tick();
    tick();
    tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    sb_q.push_back({32'd0, 32'd0});
    read_hl("mid_rst");

    sb_q.push_back({32'd0, 32'd42});
    run_op("mult_after_rst", MD_MULT, 32'd6, 32'd7, 5, -1);
    read_hl("mult_after_rst");

    chk("sb_drained", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
